// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GeMM output-tile writeback path.
package gemm_pkg;

  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } wb_state_e;

  localparam int unsigned OutDataWidthDflt = 32;
  localparam int unsigned ColParDflt       = 16;
  localparam int unsigned BeatColsDflt     = 4;
  localparam int unsigned BeatWidth        = BeatColsDflt * OutDataWidthDflt;
  localparam int unsigned BeatsPerTileRow  = ColParDflt / BeatColsDflt;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 32'd1) / den;
  endfunction

endpackage

// File: rtl/gemm_wb_addr_gen.sv
// Beat/row walker for one captured tile: clipping extents, SRAM C beat address
// and per-element strobes for the beat currently presented.
module gemm_wb_addr_gen
  import gemm_pkg::*;
#(
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned BeatCols      = 4,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  localparam int unsigned TileBeats    = ColPar / BeatCols,
  localparam int unsigned RowCntW      = $clog2(RowPar + 1),
  localparam int unsigned BeatCntW     = $clog2(TileBeats + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic                     advance_i,
  input  logic [SizeAddrWidth-1:0] m_size_i,
  input  logic [SizeAddrWidth-1:0] n_size_i,
  input  logic [SizeAddrWidth-1:0] tile_row_i,
  input  logic [SizeAddrWidth-1:0] tile_col_i,
  output logic                     empty_o,
  output logic                     last_o,
  output logic [RowCntW-1:0]       row_o,
  output logic [BeatCntW-1:0]      beat_o,
  output logic [AddrWidth-1:0]     addr_o,
  output logic [BeatCols-1:0]      strb_o
);

  localparam int unsigned ExtW = SizeAddrWidth + $clog2(RowPar + ColPar) + 1;

  logic [ExtW-1:0]      row_base_s, col_base_s, rows_left_s, cols_left_s;
  logic [RowCntW-1:0]   vrows_s;
  logic [BeatCntW-1:0]  vbeats_s;
  logic [AddrWidth-1:0] nbeats_row_s, col_beat_base_s;
  int unsigned          beats_left_s;

  logic [ExtW-1:0]      row_base_q, row_base_d, col_base_q, col_base_d, n_q, n_d;
  logic [AddrWidth-1:0] nbeats_row_q, nbeats_row_d, col_beat_base_q, col_beat_base_d;
  logic [RowCntW-1:0]   vrows_q, vrows_d, r_q, r_d;
  logic [BeatCntW-1:0]  vbeats_q, vbeats_d, b_q, b_d;
  logic [ExtW-1:0]      gr_s;

  // Extents of the incoming tile, evaluated on the live inputs at capture.
  always_comb begin
    row_base_s      = ExtW'(tile_row_i) * ExtW'(RowPar);
    col_base_s      = ExtW'(tile_col_i) * ExtW'(ColPar);
    rows_left_s     = (ExtW'(m_size_i) > row_base_s) ? ExtW'(m_size_i) - row_base_s : ExtW'(0);
    cols_left_s     = (ExtW'(n_size_i) > col_base_s) ? ExtW'(n_size_i) - col_base_s : ExtW'(0);
    vrows_s         = (rows_left_s >= ExtW'(RowPar)) ? RowCntW'(RowPar) : RowCntW'(rows_left_s);
    beats_left_s    = ceil_div(32'(cols_left_s), BeatCols);
    vbeats_s        = (beats_left_s >= TileBeats) ? BeatCntW'(TileBeats) : BeatCntW'(beats_left_s);
    nbeats_row_s    = AddrWidth'(ceil_div(32'(n_size_i), BeatCols));
    col_beat_base_s = AddrWidth'(32'(tile_col_i) * TileBeats);
    empty_o         = (vrows_s == RowCntW'(0)) || (vbeats_s == BeatCntW'(0));
  end

  always_comb begin
    row_base_d      = row_base_q;
    col_base_d      = col_base_q;
    n_d             = n_q;
    nbeats_row_d    = nbeats_row_q;
    col_beat_base_d = col_beat_base_q;
    vrows_d         = vrows_q;
    vbeats_d        = vbeats_q;
    r_d             = r_q;
    b_d             = b_q;
    if (clear_i) begin
      row_base_d      = '0;
      col_base_d      = '0;
      n_d             = '0;
      nbeats_row_d    = '0;
      col_beat_base_d = '0;
      vrows_d         = '0;
      vbeats_d        = '0;
      r_d             = '0;
      b_d             = '0;
    end else if (load_i) begin
      row_base_d      = row_base_s;
      col_base_d      = col_base_s;
      n_d             = ExtW'(n_size_i);
      nbeats_row_d    = nbeats_row_s;
      col_beat_base_d = col_beat_base_s;
      vrows_d         = vrows_s;
      vbeats_d        = vbeats_s;
      r_d             = '0;
      b_d             = '0;
    end else if (advance_i) begin
      if (b_q == vbeats_q - BeatCntW'(1)) begin
        b_d = '0;
        r_d = r_q + RowCntW'(1);
      end else begin
        b_d = b_q + BeatCntW'(1);
      end
    end else begin
      b_d = b_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_base_q      <= '0;
      col_base_q      <= '0;
      n_q             <= '0;
      nbeats_row_q    <= '0;
      col_beat_base_q <= '0;
      vrows_q         <= '0;
      vbeats_q        <= '0;
      r_q             <= '0;
      b_q             <= '0;
    end else begin
      row_base_q      <= row_base_d;
      col_base_q      <= col_base_d;
      n_q             <= n_d;
      nbeats_row_q    <= nbeats_row_d;
      col_beat_base_q <= col_beat_base_d;
      vrows_q         <= vrows_d;
      vbeats_q        <= vbeats_d;
      r_q             <= r_d;
      b_q             <= b_d;
    end
  end

  // Address arithmetic deliberately truncates to AddrWidth, wrapping the matrix in SRAM C.
  always_comb begin
    gr_s   = row_base_q + ExtW'(r_q);
    addr_o = AddrWidth'(gr_s) * nbeats_row_q + col_beat_base_q + AddrWidth'(b_q);
    strb_o = '0;
    for (int unsigned i = 0; i < BeatCols; i++) begin
      strb_o[i] = (col_base_q + ExtW'(b_q) * ExtW'(BeatCols) + ExtW'(i)) < n_q;
    end
    last_o = (b_q == vbeats_q - BeatCntW'(1)) && (r_q == vrows_q - RowCntW'(1));
    row_o  = r_q;
    beat_o = b_q;
  end

endmodule

// File: rtl/gemm_tile_writeback.sv
// GeMM drain stage: buffers one RowPar x ColPar result tile and writes it
// row-major into SRAM C as clipped, strobed beats.
module gemm_tile_writeback
  import gemm_pkg::*;
#(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned BeatCols      = 4,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  localparam int unsigned BeatBits     = BeatCols * OutDataWidth,
  localparam int unsigned TileBits     = RowPar * ColPar * OutDataWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     tile_valid_i,
  output logic                     tile_ready_o,
  input  logic [SizeAddrWidth-1:0] tile_row_i,
  input  logic [SizeAddrWidth-1:0] tile_col_i,
  input  logic [TileBits-1:0]      tile_data_i,
  output logic                     sram_c_we_o,
  input  logic                     sram_c_gnt_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic [BeatBits-1:0]      sram_c_wdata_o,
  output logic [BeatCols-1:0]      sram_c_strb_o,
  output logic                     busy_o,
  output logic                     tile_done_o
);

  localparam int unsigned TileBeats = ColPar / BeatCols;
  localparam int unsigned RowCntW   = $clog2(RowPar + 1);
  localparam int unsigned BeatCntW  = $clog2(TileBeats + 1);

  wb_state_e           state_q, state_d;
  logic                we_q, we_d, done_q, done_d;
  logic [TileBits-1:0] data_q, data_d, shifted_s;
  logic                capture_s, advance_s, last_grant_s, empty_s, last_s;
  logic [RowCntW-1:0]  row_s;
  logic [BeatCntW-1:0] beat_s;

  gemm_wb_addr_gen #(
    .RowPar        (RowPar),
    .ColPar        (ColPar),
    .BeatCols      (BeatCols),
    .AddrWidth     (AddrWidth),
    .SizeAddrWidth (SizeAddrWidth)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .load_i     (capture_s),
    .advance_i  (advance_s),
    .m_size_i   (M_size_i),
    .n_size_i   (N_size_i),
    .tile_row_i (tile_row_i),
    .tile_col_i (tile_col_i),
    .empty_o    (empty_s),
    .last_o     (last_s),
    .row_o      (row_s),
    .beat_o     (beat_s),
    .addr_o     (sram_c_addr_o),
    .strb_o     (sram_c_strb_o)
  );

  // The final grant frees the buffer in the same cycle so a waiting tile drains without a bubble.
  always_comb begin
    last_grant_s = we_q && sram_c_gnt_i && last_s;
    tile_ready_o = (state_q == WB_IDLE) || last_grant_s;
    capture_s    = tile_valid_i && tile_ready_o && !clear_i;
    advance_s    = we_q && sram_c_gnt_i && !clear_i;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    done_d  = 1'b0;
    data_d  = data_q;
    if (clear_i) begin
      state_d = WB_IDLE;
      we_d    = 1'b0;
      data_d  = '0;
    end else if (capture_s) begin
      data_d  = tile_data_i;
      state_d = WB_DRAIN;
      if (empty_s) begin
        we_d   = 1'b0;
        done_d = 1'b1;
      end else begin
        we_d   = 1'b1;
        done_d = last_grant_s;
      end
    end else if (last_grant_s) begin
      state_d = WB_IDLE;
      we_d    = 1'b0;
      done_d  = 1'b1;
    end else if ((state_q == WB_DRAIN) && !we_q) begin
      state_d = WB_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WB_IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    shifted_s      = data_q >> (BeatBits * (32'(row_s) * TileBeats + 32'(beat_s)));
    sram_c_wdata_o = shifted_s[BeatBits-1:0];
    sram_c_we_o    = we_q;
    busy_o         = (state_q == WB_DRAIN);
    tile_done_o    = done_q;
  end

endmodule
